// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg
// Shared definitions for the iterative bitwise logic unit:
//   - op encodings for AND / OR / XOR / XNOR
//   - FSM state encoding used by logic_unit_iter
package logic_unit_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_XNOR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/logic_slice.sv
// logic_slice
// Purely combinational SLICE-bit bitwise operator, reused every RUN cycle
// by logic_unit_iter.
// Ports:
//   a_i, b_i  [SLICE]  slice operands
//   op_i      [2]      operation select (OP_AND/OP_OR/OP_XOR/OP_XNOR)
//   y_o       [SLICE]  slice result
//   y_zero_o  [1]      1 when y_o is all zeros
module logic_slice
  import logic_unit_pkg::*;
#(
  parameter int SLICE = 16
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic [1:0]       op_i,
  output logic [SLICE-1:0] y_o,
  output logic             y_zero_o
);

  always_comb begin
    y_o = '0;
    case (op_i)
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_XNOR: y_o = ~(a_i ^ b_i);
      default: y_o = '0;
    endcase
  end

  assign y_zero_o = ~|y_o;

endmodule

// File: rtl/logic_unit_iter.sv
// logic_unit_iter
// Multi-cycle bitwise logic unit: processes one SLICE-bit slice of the
// WIDTH-bit operands per cycle through a single shared logic_slice, and
// accumulates a zero flag across slices. WIDTH must be a multiple of SLICE.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for a request, in_ready_o=1
// S_RUN  | one slice processed per edge, idx_q selects the slice
// S_DONE | result_o/zero_o valid and held until out_ready_i
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   in_valid_i    request valid          in_ready_o   request accepted
//   op_i          operation select       a_i, b_i     WIDTH-bit operands
//   out_valid_o   result valid           out_ready_i  consumer accepts
//   result_o      WIDTH-bit result       zero_o       1 iff result == 0
module logic_unit_iter
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o
);

  localparam int NS = WIDTH / SLICE;
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NS - 1);

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             zacc_q, zacc_d;

  logic [SLICE-1:0] s_y;
  logic             s_zero;
  logic             accept;

  logic_slice #(.SLICE(SLICE)) u_slice (
    .a_i      (a_q[idx_q*SLICE +: SLICE]),
    .b_i      (b_q[idx_q*SLICE +: SLICE]),
    .op_i     (op_q),
    .y_o      (s_y),
    .y_zero_o (s_zero)
  );

  // in_ready_o follows out_ready_i combinationally so a DONE result can
  // hand off and a new request can be taken on the same edge.
  assign in_ready_o  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready_i);
  assign out_valid_o = (state_q == S_DONE);
  assign accept      = in_valid_i && in_ready_o;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    zero_d   = zero_q;
    zacc_d   = zacc_q;

    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_RUN;
      end
      S_RUN: begin
        result_d[idx_q*SLICE +: SLICE] = s_y;
        zacc_d = zacc_q & s_zero;
        if (idx_q == IDX_LAST) begin
          zero_d  = zacc_q & s_zero;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_DONE: begin
        if (out_ready_i) state_d = accept ? S_RUN : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Capture overrides the holds above; result/zero are left alone so a
    // back-to-back request overwrites them slice by slice.
    if (accept) begin
      a_d    = a_i;
      b_d    = b_i;
      op_d   = op_i;
      idx_d  = '0;
      zacc_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_AND;
      result_q <= '0;
      zero_q   <= 1'b0;
      zacc_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      zacc_q   <= zacc_d;
    end
  end

  assign result_o = result_q;
  assign zero_o   = zero_q;

endmodule

// File: tb/tb_logic_unit_iter.sv
module tb_logic_unit_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  op = 2'b00;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;
  logic        zero;

  logic       in_valid8 = 1'b0;
  logic       in_ready8;
  logic [1:0] op8 = 2'b00;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       out_valid8;
  logic       out_ready8 = 1'b1;
  logic [7:0] result8;
  logic       zero8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic_unit_iter #(.WIDTH(64), .SLICE(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op_i(op), .a_i(a), .b_i(b),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .result_o(result), .zero_o(zero)
  );

  logic_unit_iter #(.WIDTH(8), .SLICE(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid8), .in_ready_o(in_ready8),
    .op_i(op8), .a_i(a8), .b_i(b8),
    .out_valid_o(out_valid8), .out_ready_i(out_ready8),
    .result_o(result8), .zero_o(zero8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request, return edges from accept to out_valid (-1 on timeout).
  task automatic do_op(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                       output int lat);
    in_valid = 1'b1; op = o; a = x; b = y;
    tick();
    in_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (out_valid) begin lat = k; break; end
    end
  endtask

  task automatic test_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (result !== 64'h0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL reset_zero got %b want 0", zero); end
    checks++; if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || result8 !== 8'h0 || zero8 !== 1'b0) begin
      errors++; $display("FAIL reset_ns1 got rdy=%b vld=%b res=%h z=%b want 1 0 00 0",
                         in_ready8, out_valid8, result8, zero8);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_and();
    int lat;
    out_ready = 1'b1;
    do_op(2'b00, 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL and_latency got %0d want 4", lat); end
    checks++; if (result !== 64'h0F0F_0000_0F0F_0000) begin errors++; $display("FAIL and_result got %h want 0f0f00000f0f0000", result); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL and_zero got %b want 0", zero); end
    tick();
  endtask

  task automatic test_xor_zero();
    int lat;
    do_op(2'b10, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, lat);
    checks++; if (result !== 64'h0 || zero !== 1'b1) begin
      errors++; $display("FAIL xor_equal got res=%h z=%b want 0 1", result, zero);
    end
    tick();
    do_op(2'b10, 64'h1234_5678_9ABC_DEF0, 64'h9234_5678_9ABC_DEF0, lat);
    checks++; if (result !== 64'h8000_0000_0000_0000 || zero !== 1'b0) begin
      errors++; $display("FAIL xor_bit63 got res=%h z=%b want 8000000000000000 0", result, zero);
    end
    tick();
    do_op(2'b10, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF1, lat);
    checks++; if (result !== 64'h1 || zero !== 1'b0) begin
      errors++; $display("FAIL xor_bit0 got res=%h z=%b want 1 0", result, zero);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    out_ready = 1'b0;
    do_op(2'b01, 64'h00FF_00FF_0000_1111, 64'h1100_0000_2222_0000, lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL bp_latency got %0d want 4", lat); end
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || zero !== 1'b0 ||
          result !== 64'h11FF_00FF_2222_1111) bad++;
      tick();
    end
    checks++; if (bad != 0) begin
      errors++; $display("FAIL bp_hold got %0d bad cycles want 0 (res=%h vld=%b rdy=%b)", bad, result, out_valid, in_ready);
    end
    out_ready = 1'b1;
    in_valid = 1'b1; op = 2'b11; a = 64'hFFFF_0000_AAAA_5555; b = 64'hFFFF_FFFF_5555_5555;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_comb got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || result !== 64'h11FF_00FF_2222_1111) begin
      errors++; $display("FAIL bp_same_edge got vld=%b res=%h want 0 11ff00ff22221111", out_valid, result);
    end
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (out_valid) begin lat = k; break; end
    end
    checks++; if (lat != 4) begin errors++; $display("FAIL bp_next_latency got %0d want 4", lat); end
    checks++; if (result !== 64'hFFFF_0000_0000_FFFF || zero !== 1'b0) begin
      errors++; $display("FAIL bp_xnor got res=%h z=%b want ffff00000000ffff 0", result, zero);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    in_valid = 1'b1; op = 2'b01; a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h0;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    checks++; if (result !== 64'h0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid got res=%h vld=%b rdy=%b want 0 0 1", result, out_valid, in_ready);
    end
    tick();
    tick();
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (out_valid) seen++;
    end
    checks++; if (seen != 0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_abort got %0d valid cycles rdy=%b want 0 1", seen, in_ready);
    end
    do_op(2'b11, 64'h0, 64'h0, lat);
    checks++; if (lat != 4 || result !== 64'hFFFF_FFFF_FFFF_FFFF || zero !== 1'b0) begin
      errors++; $display("FAIL rst_xnor got lat=%0d res=%h z=%b want 4 ffffffffffffffff 0", lat, result, zero);
    end
    tick();
  endtask

  task automatic test_operand_change();
    int lat;
    in_valid = 1'b1; op = 2'b10; a = 64'hDEAD_BEEF_0000_0001; b = 64'h0000_0000_0000_0001;
    tick();
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      in_valid = 1'b0;
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; op = 2'($urandom_range(0, 3));
      tick();
      if (out_valid) begin lat = k; break; end
    end
    checks++; if (lat != 4 || result !== 64'hDEAD_BEEF_0000_0000 || zero !== 1'b0) begin
      errors++; $display("FAIL opchange got lat=%0d res=%h z=%b want 4 deadbeef00000000 0", lat, result, zero);
    end
    tick();
  endtask

  task automatic test_ns1();
    int lat;
    in_valid8 = 1'b1; op8 = 2'b01; a8 = 8'h00; b8 = 8'h00;
    tick();
    in_valid8 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (out_valid8) begin lat = k; break; end
    end
    checks++; if (lat != 1 || result8 !== 8'h00 || zero8 !== 1'b1) begin
      errors++; $display("FAIL ns1_or got lat=%0d res=%h z=%b want 1 00 1", lat, result8, zero8);
    end
    tick();
    in_valid8 = 1'b1; op8 = 2'b00; a8 = 8'hF0; b8 = 8'h3C;
    tick();
    in_valid8 = 1'b0;
    tick();
    checks++; if (out_valid8 !== 1'b1 || result8 !== 8'h30 || zero8 !== 1'b0) begin
      errors++; $display("FAIL ns1_and got vld=%b res=%h z=%b want 1 30 0", out_valid8, result8, zero8);
    end
    tick();
  endtask

  initial begin
    #2;
    test_reset();
    test_and();
    test_xor_zero();
    test_backpressure();
    test_reset_mid();
    test_operand_change();
    test_ns1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
